ps2_rx: RTL and testbench
=========================

// Module: ps2_rx
// PURPOSE
//   PS/2 device-to-host frame receiver sitting directly between the ps2_clk/ps2_data
//   pins and the keyboard register block. Synchronises and de-glitches both lines,
//   deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop) and presents
//   each good byte as a one-cycle strobe. Bad frames yield an error strobe; a watchdog
//   aborts stalled frames. All logic runs in the clk_100 domain.
// PARAMETERS
//   FILTER_LEN      8        consecutive equal synced ps2_clk samples needed to change filtered clock
//   TIMEOUT_CYCLES  200000   max clk cycles between falling edges inside a frame (2 ms @ 100 MHz)
// PORTS
//   clk       in   1  system clock (clk_100)
//   reset_n   in   1  asynchronous active-low reset
//   ps2_clk   in   1  raw PS/2 clock pin (asynchronous)
//   ps2_data  in   1  raw PS/2 data pin (asynchronous)
//   rx_data   out  8  last good scancode byte; held until next good frame
//   rx_valid  out  1  1-cycle pulse: rx_data just updated
//   rx_err    out  1  1-cycle pulse: parity, stop-bit or timeout error
//   busy      out  1  high while a frame is in progress (state != IDLE)
// BEHAVIOUR
//   Reset: rx_data=0x00, rx_valid=0, rx_err=0, busy=0, state=IDLE, filtered clk=1,
//     sync FFs=1, counters=0. Reset may assert at any cycle; partial frame discarded.
//   Sync: 2-FF synchroniser on each pin; all logic uses synced values only.
//   Filter: counter counts consecutive synced ps2_clk samples differing from filtered
//     clk; on reaching FILTER_LEN filtered clk toggles, counter clears; any sample equal
//     to filtered clk clears counter. Pulses shorter than FILTER_LEN cycles are ignored.
//   Edge: fall = filtered clk 1->0, one-cycle strobe; data bit = synced ps2_data that cycle.
//   FSM (advances only on fall, except timeout):
//     IDLE  : bit==0 -> DATA, bit_cnt=0; bit==1 -> stay IDLE, no error (stray edge).
//     DATA  : shift bit into shreg[7] (shift right), bit_cnt++; after 8th bit -> PARITY.
//     PARITY: store bit -> STOP.
//     STOP  : bit==1 and ^{shreg,parity}==1 -> rx_data<=shreg, rx_valid next cycle;
//             else rx_err next cycle (rx_data unchanged). Always -> IDLE.
//   Latency: rx_valid/rx_err is high on the cycle after the STOP-state fall strobe,
//     i.e. FILTER_LEN+3 clk edges after the first edge that samples the stop-bit ps2_clk low.
//   Timeout: counter cleared on every fall and while IDLE; counts in DATA/PARITY/STOP;
//     at TIMEOUT_CYCLES -> rx_err pulse, state=IDLE. Timeout and fall on same cycle:
//     fall wins (counter clears, FSM advances).
//   rx_valid and rx_err are never high together; each is high exactly one cycle.
//   No flow control: a new good frame overwrites rx_data; consumer must take it on the strobe.
//   Back-to-back frames: a start bit accepted on the first fall after STOP, no gap needed.
// TESTING
//   1 frame 0x1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1) at 12.5 kHz -> rx_valid once, rx_data=0x1C, rx_err never.
//   2 frames 0xF0 then 0x1C back-to-back -> two rx_valid pulses, rx_data 0xF0 then 0x1C.
//   3 0x1C with parity 1 -> one rx_err pulse, rx_data keeps prior value, busy drops.
//   4 0x1C with stop bit 0 -> rx_err pulse; following good 0x5A frame -> rx_valid, rx_data=0x5A.
//   5 4-cycle low glitches on ps2_clk while IDLE and mid-frame -> no state change; frame still decodes.
//   6 stop clocking after 4 data bits -> rx_err exactly TIMEOUT_CYCLES after last fall; reset_n low mid-frame -> all outputs reset values, next frame decodes.

Source files
------------

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: synchronises and de-glitches the pins, then
// deserialises start/8 data/odd parity/stop frames into one-cycle byte or error strobes.
module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       busy
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic          r_clkMeta;
    logic          r_clkSync;
    logic          r_dataMeta;
    logic          r_dataSync;
    logic          r_clkFilt;
    logic          r_clkFiltPrev;
    logic [FW-1:0] r_filtCnt;

    logic [1:0]    r_state;
    logic [2:0]    r_bitCnt;
    logic [7:0]    r_shreg;
    logic          r_parity;
    logic [7:0]    r_rxData;
    logic          r_rxValid;
    logic          r_rxErr;
    logic [TW-1:0] r_toCnt;

    logic          w_fall;
    logic          w_bit;

    assign w_fall = r_clkFiltPrev & ~r_clkFilt;
    assign w_bit  = r_dataSync;

    // The filtered clock only flips after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clkMeta     <= 1'b1;
            r_clkSync     <= 1'b1;
            r_dataMeta    <= 1'b1;
            r_dataSync    <= 1'b1;
            r_clkFilt     <= 1'b1;
            r_clkFiltPrev <= 1'b1;
            r_filtCnt     <= '0;
        end else begin
            r_clkMeta     <= ps2_clk;
            r_clkSync     <= r_clkMeta;
            r_dataMeta    <= ps2_data;
            r_dataSync    <= r_dataMeta;
            r_clkFiltPrev <= r_clkFilt;
            if (r_clkSync != r_clkFilt) begin
                if (r_filtCnt == FW'(FILTER_LEN - 1)) begin
                    r_clkFilt <= r_clkSync;
                    r_filtCnt <= '0;
                end else begin
                    r_filtCnt <= r_filtCnt + 1'b1;
                end
            end else begin
                r_filtCnt <= '0;
            end
        end
    end

    // A fall strobe always takes priority over the watchdog expiring in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_bitCnt  <= '0;
            r_shreg   <= '0;
            r_parity  <= 1'b0;
            r_rxData  <= '0;
            r_rxValid <= 1'b0;
            r_rxErr   <= 1'b0;
            r_toCnt   <= '0;
        end else begin
            r_rxValid <= 1'b0;
            r_rxErr   <= 1'b0;
            if (w_fall) begin
                r_toCnt <= '0;
                case (r_state)
                    IDLE: begin
                        if (!w_bit) begin
                            r_state  <= DATA;
                            r_bitCnt <= '0;
                        end
                    end
                    DATA: begin
                        r_shreg  <= {w_bit, r_shreg[7:1]};
                        r_bitCnt <= r_bitCnt + 1'b1;
                        if (r_bitCnt == 3'd7) begin
                            r_state <= PARITY;
                        end
                    end
                    PARITY: begin
                        r_parity <= w_bit;
                        r_state  <= STOP;
                    end
                    STOP: begin
                        if (w_bit && (^{r_shreg, r_parity})) begin
                            r_rxData  <= r_shreg;
                            r_rxValid <= 1'b1;
                        end else begin
                            r_rxErr <= 1'b1;
                        end
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end else if (r_state == IDLE) begin
                r_toCnt <= '0;
            end else if (r_toCnt == TW'(TIMEOUT_CYCLES - 1)) begin
                r_rxErr <= 1'b1;
                r_state <= IDLE;
                r_toCnt <= '0;
            end else begin
                r_toCnt <= r_toCnt + 1'b1;
            end
        end
    end

    assign rx_data  = r_rxData;
    assign rx_valid = r_rxValid;
    assign rx_err   = r_rxErr;
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: drives PS/2 frames, pushes the expected strobe into a queue
// and compares each rx_valid/rx_err strobe against the head of that queue.
module tb_ps2_rx;

    localparam int FL   = 8;
    localparam int TO   = 2000;
    localparam int HALF = 40;

    typedef struct packed {
        logic       isErr;
        logic [7:0] data;
    } event_t;

    logic       clk;
    logic       reset_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       busy;

    int         checks;
    int         failures;
    event_t     expQ[$];
    logic       prevStrobe;

    ps2_rx #(
        .FILTER_LEN(FL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_err(rx_err),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendBit(input logic b, input logic glitch);
        ps2_data = b;
        waitCycles(4);
        if (glitch) begin
            ps2_clk = 1'b0;
            waitCycles(4);
            ps2_clk = 1'b1;
            waitCycles(HALF / 2 - 8);
        end else begin
            waitCycles(HALF / 2 - 4);
        end
        ps2_clk = 1'b0;
        waitCycles(HALF);
        ps2_clk = 1'b1;
        waitCycles(HALF / 2);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic badParity,
                                 input logic stopBit, input logic glitch);
        logic par;
        par = (~^data) ^ badParity;
        sendBit(1'b0, glitch);
        for (int i = 0; i < 8; i++) sendBit(data[i], glitch);
        sendBit(par, glitch);
        sendBit(stopBit, glitch);
    endtask

    task automatic expectByte(input logic [7:0] d);
        event_t e;
        e.isErr = 1'b0;
        e.data  = d;
        expQ.push_back(e);
    endtask

    task automatic expectErr(input logic [7:0] held);
        event_t e;
        e.isErr = 1'b1;
        e.data  = held;
        expQ.push_back(e);
    endtask

    // Every strobe is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n) begin
            if (prevStrobe) checkOutput("pulse_width", 32'(rx_valid | rx_err), 32'd0);
            if (rx_valid || rx_err) begin
                checkOutput("exclusive", 32'(rx_valid & rx_err), 32'd0);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_strobe", 32'({rx_err, rx_valid}), 32'd0);
                end else begin
                    event_t e;
                    e = expQ.pop_front();
                    checkOutput("strobe_kind", 32'(rx_err), 32'(e.isErr));
                    checkOutput("rx_data", 32'(rx_data), 32'(e.data));
                end
            end
            prevStrobe = rx_valid | rx_err;
        end else begin
            prevStrobe = 1'b0;
        end
    end

    initial begin
        int idx;
        checks     = 0;
        failures   = 0;
        prevStrobe = 1'b0;
        reset_n    = 1'b0;
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        waitCycles(5);
        checkOutput("reset_rx_data", 32'(rx_data), 32'h00);
        checkOutput("reset_valid", 32'(rx_valid), 32'd0);
        checkOutput("reset_err", 32'(rx_err), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        waitCycles(20);

        $display("[TB] single frame 0x1C");
        expectByte(8'h1C);
        applyStimulus(8'h1C, 1'b0, 1'b1, 1'b0);
        waitCycles(20);
        checkOutput("busy_after_good", 32'(busy), 32'd0);

        $display("[TB] back-to-back 0xF0 0x1C");
        expectByte(8'hF0);
        expectByte(8'h1C);
        applyStimulus(8'hF0, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h1C, 1'b0, 1'b1, 1'b0);
        waitCycles(20);

        $display("[TB] parity error");
        expectErr(8'h1C);
        applyStimulus(8'h1C, 1'b1, 1'b1, 1'b0);
        waitCycles(FL + 10);
        checkOutput("busy_after_parity_err", 32'(busy), 32'd0);

        $display("[TB] stop-bit error then 0x5A");
        expectErr(8'h1C);
        applyStimulus(8'h1C, 1'b0, 1'b0, 1'b0);
        expectByte(8'h5A);
        applyStimulus(8'h5A, 1'b0, 1'b1, 1'b0);
        waitCycles(20);

        $display("[TB] clock glitches");
        ps2_clk = 1'b0;
        waitCycles(4);
        ps2_clk = 1'b1;
        waitCycles(FL + 6);
        checkOutput("idle_glitch_busy", 32'(busy), 32'd0);
        expectByte(8'hA5);
        applyStimulus(8'hA5, 1'b0, 1'b1, 1'b1);
        waitCycles(20);

        $display("[TB] watchdog timeout");
        expectErr(8'hA5);
        sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0);
        sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0);
        ps2_data = 1'b1;
        waitCycles(HALF / 2);
        ps2_clk = 1'b0;
        idx = -1;
        for (int k = 1; k <= FL + 3 + TO + 20; k++) begin
            @(negedge clk);
            if (k == HALF) ps2_clk = 1'b1;
            if (rx_err && idx < 0) idx = k;
        end
        checkOutput("timeout_latency", 32'(idx), 32'(FL + 3 + TO));
        checkOutput("busy_after_timeout", 32'(busy), 32'd0);

        $display("[TB] reset mid-frame");
        sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0);
        sendBit(1'b0, 1'b0);
        checkOutput("busy_midframe", 32'(busy), 32'd1);
        reset_n = 1'b0;
        waitCycles(3);
        checkOutput("midreset_rx_data", 32'(rx_data), 32'h00);
        checkOutput("midreset_valid", 32'(rx_valid), 32'd0);
        checkOutput("midreset_err", 32'(rx_err), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        waitCycles(2 * HALF);
        expectByte(8'h3C);
        applyStimulus(8'h3C, 1'b0, 1'b1, 1'b0);
        waitCycles(200);
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
